// File: rtl/inst_mem_resp.sv
// Instruction-fetch responder: accepts one fetch request at a time and
// returns the 32-bit instruction word LATENCY cycles after acceptance.
// The word-addressed store is filled through a separate load port.
// Build option: define INST_MEM_NOP_ON_ERR_EN so faulting fetches return a
// NOP (addi x0,x0,0) instead of an all-zero word.
module inst_mem_resp #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [63:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

`ifdef INST_MEM_NOP_ON_ERR_EN
    localparam logic [31:0] ERR_INST = 32'h0000_0013;
`else
    localparam logic [31:0] ERR_INST = 32'h0000_0000;
`endif

    logic [31:0]      mem [DEPTH];
    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [63:0]      addr_q;

    logic             accept;
    logic [63:0]      fetch_addr;
    logic             fetch_err;
    logic [IDX_W-1:0] fetch_idx;
    logic             ld_ok;
    logic [IDX_W-1:0] ld_idx;

    // Word offset from the base; 64-bit unsigned, so addresses below the
    // base wrap to huge values and are rejected by the explicit compare.
    function automatic logic [61:0] word_off(input logic [63:0] a);
        return 62'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic addr_fault(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || (word_off(a) >= 62'(DEPTH));
    endfunction

    // Handshake and address decode for the read that happens on RESP entry;
    // with LATENCY==1 that read happens on the accepting edge, so the live
    // request address is used while IDLE.
    always_comb begin
        req_ready  = (state == IDLE) && !flush && !rst;
        accept     = req_valid && req_ready;
        fetch_addr = (state == IDLE) ? req_addr : addr_q;
        fetch_err  = addr_fault(fetch_addr);
        fetch_idx  = IDX_W'(word_off(fetch_addr));
        ld_ok      = !addr_fault(ld_addr);
        ld_idx     = IDX_W'(word_off(ld_addr));
    end

    // Load port: independent of the FSM; NBA ordering makes a same-edge
    // fetch of the written word return the old contents.
    always_ff @(posedge clk) begin
        if (ld_en && ld_ok) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // Request/latency/response FSM; flush outranks every other event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= 64'd0;
            rsp_valid <= 1'b0;
            rsp_inst  <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        cnt    <= CNT_INIT;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= fetch_err;
                            rsp_inst  <= fetch_err ? ERR_INST : mem[fetch_idx];
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= fetch_err;
                        rsp_inst  <= fetch_err ? ERR_INST : mem[fetch_idx];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (flush || rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
- Responder side of the instruction-fetch interface: accepts fetch requests from the PC/fetch stage and returns one 32-bit RV64 instruction word per request after a programmable latency.
- Backed by a word-addressed instruction store, preloaded by the testbench through a dedicated load port.
- Replaces the combinational instaddr/ce-to-inst path, giving the core a handshaked, multi-cycle memory to fetch from.

Parameters:
- DEPTH, 1024: number of 32-bit instruction words; power of two.
- LATENCY, 2: cycles from request acceptance to rsp_valid; legal range 1..15.
- BASE_ADDR, 64'h0000_0000_8000_0000: byte address of word 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_addr  input  64  byte address of the requested instruction.
- req_ready  output  1  responder can accept a request this cycle.
- flush  input  1  kill any in-flight or pending fetch (branch/redirect).
- rsp_valid  output  1  rsp_inst/rsp_err valid.
- rsp_ready  input  1  fetch stage consumes the response.
- rsp_inst  output  32  instruction word.
- rsp_err  output  1  fetch fault (misaligned or out of range).
- ld_en  input  1  load-port write enable.
- ld_addr  input  64  load-port byte address (word-aligned, in range; otherwise ignored).
- ld_data  input  32  load-port write data.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, rsp_inst=32'h0, rsp_err=0, latency counter=0, latched address=0. req_ready=0 while rst is high. Memory contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- req_ready:
  - Combinational: 1 only when state==IDLE, flush==0 and rst==0.
  - Throughput is at most one request per LATENCY+1 cycles.
- IDLE:
  - On req_valid&&req_ready, latch req_addr and load cnt=LATENCY-1.
  - Next state is RESP if LATENCY==1, otherwise BUSY.
- BUSY:
  - If cnt==1, next state is RESP; otherwise cnt decrements.
  - rsp_valid asserts exactly LATENCY rising edges after the accepting edge.
- Entry to RESP (same edge):
  - Compute idx=(addr-BASE_ADDR)>>2.
  - err = (addr[1:0]!=0) | (addr<BASE_ADDR) | (idx>=DEPTH).
  - rsp_inst = err ? 32'h0 : mem[idx]; rsp_err=err; rsp_valid=1.
- RESP:
  - rsp_valid, rsp_inst and rsp_err are held stable until rsp_ready==1.
  - On the handshake edge: rsp_valid=0 and next state is IDLE. No new request is accepted on that same edge.
- Flush:
  - flush has priority over every other event.
  - In BUSY or RESP, the next state is IDLE, rsp_valid=0 and no response is produced for the killed request.
  - In IDLE, req_ready is forced low, so a concurrent req_valid is not accepted.
- Load port:
  - On ld_en, write mem[(ld_addr-BASE_ADDR)>>2]=ld_data when ld_addr is aligned and in range; otherwise no write and no side effect.
  - Load-port writes are independent of the FSM.
  - Same-edge collision with a RESP-entry read of the same word is read-before-write: the response returns the old word and the new word is visible to later fetches.
- Reset mid-operation: rst asserted in any state forces IDLE and drops the pending response immediately.
- Arithmetic: the address subtraction is 64-bit unsigned. addr<BASE_ADDR is checked explicitly, so wrap-around never yields a valid index.

Optional Feature:
- Macro: INST_MEM_NOP_ON_ERR_EN.
- Defined: a faulting response returns rsp_inst=32'h0000_0013 (addi x0,x0,0) with rsp_err=1, so a core that ignores rsp_err executes a NOP.
- Undefined: a faulting response returns rsp_inst=32'h0 with rsp_err=1.

Test Plan:
- Basic fetch: load 32'h00500093 at 0x80000000, LATENCY=2; request addr 0x80000000 with rsp_ready=1 -> rsp_valid high exactly 2 cycles after accept, rsp_inst=32'h00500093, rsp_err=0; req_ready low through BUSY and RESP, high again the next cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_inst held constant; req_valid ignored; one transfer when rsp_ready rises.
- Faults:
  - addr 0x80000002 -> rsp_err=1, rsp_inst=0 (0x00000013 with the macro).
  - addr 0x7FFFFFFC -> rsp_err=1.
  - addr 0x80000000+4*DEPTH -> rsp_err=1.
- Flush: accept a request, assert flush in BUSY -> no rsp_valid ever appears for it. flush with req_valid in IDLE -> req_ready=0, no accept.
- Load/read collision: in the same cycle as RESP entry for word 3, write word 3 with 32'hDEADBEEF -> response carries the old value; a refetch of word 3 returns 32'hDEADBEEF.
- Reset mid-op: assert rst while in RESP -> rsp_valid falls asynchronously; after release, state is IDLE and req_ready=1. Also repeat the basic fetch with LATENCY=1 -> rsp_valid on the cycle after accept.
